mxpl_ctrl: RTL

- Sequencer for the 2x2, stride-2 max-pooling stage that follows convolution.
- Scans the convolution result memory (IMG_W x IMG_W, row-major) one 2x2 window at a time and issues the four reads for each window.
- Folds the four returned samples into a signed running maximum and writes one pooled word per window to the layer-1 memory ((IMG_W/2)^2 entries).
- Top-level FSM raises start; the block reports busy and done.

---
 rtl/mxpl_pkg.sv | 18 +
 rtl/mxpl_if.sv | 27 ++
 rtl/mxpl_acc.sv | 26 ++
 rtl/mxpl_ctrl.sv | 138 +++++++++++++
 4 files changed

// File: rtl/mxpl_pkg.sv
// Shared constants and state encoding for the 2x2 max-pooling sequencer.
package mxpl_pkg;

  localparam int DATAW_DEF = 20;
  localparam int ADDRW_DEF = 12;
  localparam int IMG_W_DEF = 64;
  localparam int POOL_W    = IMG_W_DEF / 2;
  localparam int CW        = $clog2(POOL_W);

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_RD   = 3'd1;
  localparam state_t ST_LAST = 3'd2;
  localparam state_t ST_WR   = 3'd3;
  localparam state_t ST_DONE = 3'd4;

endpackage

// File: rtl/mxpl_if.sv
// Control and memory-bus bundle between the pooling sequencer and its environment.
interface mxpl_if import mxpl_pkg::*; #(
  parameter int DATAW = DATAW_DEF,
  parameter int ADDRW = ADDRW_DEF
) ();

  logic                    start;
  logic                    busy;
  logic                    done;
  logic                    rd_en;
  logic        [ADDRW-1:0] rd_addr;
  logic signed [DATAW-1:0] rd_data;
  logic                    wr_en;
  logic        [ADDRW-1:0] wr_addr;
  logic signed [DATAW-1:0] wr_data;

  modport master (
    input  start, rd_data,
    output busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );

  modport slave (
    output start, rd_data,
    input  busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/mxpl_acc.sv
// Signed running-maximum register: load takes din, en keeps the larger of din/acc.
module mxpl_acc import mxpl_pkg::*; #(
  parameter int DATAW = DATAW_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic                    en,
  input  logic signed [DATAW-1:0] din,
  output logic signed [DATAW-1:0] acc
);

  // Running maximum; a tie leaves the stored value untouched.
  always_ff @(posedge clk) begin
    if (!reset) begin
      acc <= {DATAW{1'b0}};
    end else if (load) begin
      acc <= din;
    end else if (en && (din > acc)) begin
      acc <= din;
    end else begin
      acc <= acc;
    end
  end

endmodule

// File: rtl/mxpl_ctrl.sv
// 2x2 stride-2 max-pooling sequencer: four reads per window, one pooled write.
// Build option MXPL_RELU_EN clamps negative pooled results to zero.
module mxpl_ctrl import mxpl_pkg::*; #(
  parameter int DATAW = DATAW_DEF,
  parameter int ADDRW = ADDRW_DEF,
  parameter int IMG_W = IMG_W_DEF
) (
  input  logic   clk,
  input  logic   reset,
  mxpl_if.master bus
);

  localparam int PW  = IMG_W / 2;
  localparam int CWL = $clog2(PW);
  localparam logic [CWL-1:0] PMAX = CWL'(PW - 1);

  state_t                  state_r, state_s;
  logic        [1:0]       k_r, k_s;
  logic        [CWL-1:0]   prow_r, prow_s, pcol_r, pcol_s;
  logic                    busy_r, busy_s, done_r, done_s;
  logic                    rd_en_r, rd_en_s, wr_en_r, wr_en_s;
  logic        [ADDRW-1:0] rd_addr_r, rd_addr_s, wr_addr_r, wr_addr_s;
  logic signed [DATAW-1:0] wr_hold_r, wr_val_s, acc_s;
  logic                    acc_load_s, acc_en_s;

  // Sample for read k arrives while the sequencer already sits at k+1 (or LAST).
  assign acc_load_s = (state_r == ST_RD) && (k_r == 2'd1);
  assign acc_en_s   = ((state_r == ST_RD) && (k_r != 2'd0)) || (state_r == ST_LAST);

  mxpl_acc #(.DATAW(DATAW)) u_acc (
    .clk   (clk),
    .reset (reset),
    .load  (acc_load_s),
    .en    (acc_en_s),
    .din   (bus.rd_data),
    .acc   (acc_s)
  );

`ifdef MXPL_RELU_EN
  assign wr_val_s = acc_s[DATAW-1] ? {DATAW{1'b0}} : acc_s;
`else
  assign wr_val_s = acc_s;
`endif

  // Next-state, counter and output decode.
  always_comb begin
    state_s   = state_r;
    k_s       = k_r;
    prow_s    = prow_r;
    pcol_s    = pcol_r;
    wr_addr_s = wr_addr_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_s = ST_RD;
          k_s     = 2'd0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RD: begin
        if (k_r == 2'd3) begin
          state_s = ST_LAST;
        end else begin
          k_s = k_r + 2'd1;
        end
      end
      ST_LAST: begin
        state_s   = ST_WR;
        wr_addr_s = ADDRW'({prow_r, pcol_r});
      end
      ST_WR: begin
        k_s    = 2'd0;
        pcol_s = pcol_r + CWL'(1);
        if (pcol_r == PMAX) begin
          prow_s = prow_r + CWL'(1);
        end else begin
          prow_s = prow_r;
        end
        if ((prow_r == PMAX) && (pcol_r == PMAX)) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_RD;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase

    rd_en_s = (state_s == ST_RD);
    wr_en_s = (state_s == ST_WR);
    done_s  = (state_s == ST_DONE);
    busy_s  = (state_s == ST_RD) || (state_s == ST_LAST) || (state_s == ST_WR);
    if (rd_en_s) begin
      rd_addr_s = ADDRW'({prow_s, k_s[1], pcol_s, k_s[0]});
    end else begin
      rd_addr_s = rd_addr_r;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      k_r       <= 2'd0;
      prow_r    <= {CWL{1'b0}};
      pcol_r    <= {CWL{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      rd_en_r   <= 1'b0;
      wr_en_r   <= 1'b0;
      rd_addr_r <= {ADDRW{1'b0}};
      wr_addr_r <= {ADDRW{1'b0}};
      wr_hold_r <= {DATAW{1'b0}};
    end else begin
      state_r   <= state_s;
      k_r       <= k_s;
      prow_r    <= prow_s;
      pcol_r    <= pcol_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
      rd_en_r   <= rd_en_s;
      wr_en_r   <= wr_en_s;
      rd_addr_r <= rd_addr_s;
      wr_addr_r <= wr_addr_s;
      wr_hold_r <= wr_en_r ? wr_val_s : wr_hold_r;
    end
  end

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.rd_en   = rd_en_r;
  assign bus.rd_addr = rd_addr_r;
  assign bus.wr_en   = wr_en_r;
  assign bus.wr_addr = wr_addr_r;
  assign bus.wr_data = wr_en_r ? wr_val_s : wr_hold_r;

endmodule
